// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter.
// Word geometry of the SRAM and the arbiter FSM encoding.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // One-hot so that a corrupted register is detectable and recoverable
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b01,
    ARB_BUSY = 2'b10
  } arb_state_e;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational winner select for the SRAM port arbiter.
// Round-robin from ptr_i+1 with wrap, or fixed priority (index 0 highest).
module sram_arb_rr_pick #(
  parameter int N         = 2,
  parameter int FIXED_PRI = 0,
  localparam int IW       = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  int            k;
  logic [IW-1:0] kk;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < N; i++) begin
      if (FIXED_PRI != 0) k = i;
      else k = (int'(ptr_i) + 1 + i) % N;
      kk = IW'(k);
      if (!found && req_i[kk]) begin
        found = 1'b1;
        idx_o = kk;
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM controller among NUM_REQ requesters.
// One access in flight; read data returns with a one-hot rvalid strobe.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int FIXED_PRI = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      mem_o,
  output logic                      rw_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         wdata_o,
  input  logic                      ready_i,
  input  logic [DATA_W-1:0]         rdata_i
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               rd_pend_q, rd_pend_d;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IW-1:0]      win_idx;
  logic               ret;
  logic               issue;

  sram_arb_rr_pick #(
    .N         (NUM_REQ),
    .FIXED_PRI (FIXED_PRI)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  // BUSY with ready_i behaves as IDLE in the same cycle
  assign ret   = (state_q == ARB_BUSY) && ready_i;
  assign issue = !reset && ready_i && (|req_i) &&
                 ((state_q == ARB_IDLE) || (state_q == ARB_BUSY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      ptr_q     <= IW'(NUM_REQ - 1);
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    rd_pend_d = rd_pend_q;
    case (state_q)
      ARB_IDLE: if (issue) state_d = ARB_BUSY;
      ARB_BUSY: if (ready_i) state_d = issue ? ARB_BUSY : ARB_IDLE;
      default: begin
        state_d   = ARB_IDLE;
        rd_pend_d = 1'b0;
      end
    endcase
    if (ret) rd_pend_d = 1'b0;
    if (issue) begin
      owner_d   = win_idx;
      rd_pend_d = rw_i[win_idx];
      if (FIXED_PRI == 0) ptr_d = win_idx;
    end
  end

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    mem_o    = 1'b0;
    rw_o     = 1'b1;
    addr_o   = '0;
    wdata_o  = '0;
    if (issue) begin
      gnt_o   = win_gnt;
      mem_o   = 1'b1;
      rw_o    = rw_i[win_idx];
      addr_o  = addr_i[win_idx*ADDR_W +: ADDR_W];
      wdata_o = wdata_i[win_idx*DATA_W +: DATA_W];
    end
    if (ret && rd_pend_q) rvalid_o[owner_q] = 1'b1;
  end

  assign rdata_o = rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: round-robin and fixed-priority instances
// share stimulus; each has its own SRAM controller model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  rw = '0;
  logic [35:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [1:0]  gnt_w [2];
  logic [1:0]  rvalid_w [2];
  logic [15:0] rdata_o_w [2];
  logic [15:0] rdata_w [2];
  logic        mem_w [2];
  logic        rw_w [2];
  logic [17:0] addr_w [2];
  logic [15:0] wdata_w [2];
  logic        ready_w [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(logic [17:0] a);
    if (a == 18'h00010) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A ^ {14'b0, a[17:16]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        busy_q;
    logic [15:0] rd_q;

    sram_port_arbiter #(
      .NUM_REQ   (2),
      .ADDR_W    (18),
      .DATA_W    (16),
      .FIXED_PRI (g)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req),
      .rw_i     (rw),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .gnt_o    (gnt_w[g]),
      .rvalid_o (rvalid_w[g]),
      .rdata_o  (rdata_o_w[g]),
      .mem_o    (mem_w[g]),
      .rw_o     (rw_w[g]),
      .addr_o   (addr_w[g]),
      .wdata_o  (wdata_w[g]),
      .ready_i  (ready_w[g]),
      .rdata_i  (rdata_w[g])
    );

    assign ready_w[g] = !busy_q && !hold;
    assign rdata_w[g] = rd_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        busy_q <= 1'b0;
        rd_q   <= '0;
      end else begin
        busy_q <= mem_w[g] && ready_w[g];
        if (mem_w[g] && ready_w[g] && rw_w[g]) rd_q <= mdata(addr_w[g]);
      end
    end
  end

  // reference model state, per instance
  int          last [2];
  bit          infl [2];
  bit          infl_rd [2];
  int          infl_own [2];
  logic [15:0] infl_dat [2];
  bit          bsy [2];
  bit          e_iss [2];
  int          e_w [2];

  function automatic int pick(int fp, int lst, logic [1:0] r);
    for (int i = 0; i < 2; i++) begin
      int k;
      k = (fp != 0) ? i : (lst + 1 + i) % 2;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 2; g++) begin
      bit         rdy;
      logic [1:0] eg, erv;
      rdy      = !hold && !bsy[g];
      e_iss[g] = !reset && rdy && (req != 2'b00);
      e_w[g]   = pick(g, last[g], req);
      eg       = e_iss[g] ? 2'(1 << e_w[g]) : 2'b00;
      chk($sformatf("i%0d.gnt", g), 32'(gnt_w[g]), 32'(eg));
      chk($sformatf("i%0d.mem", g), 32'(mem_w[g]), 32'(e_iss[g]));
      chk($sformatf("i%0d.rw", g), 32'(rw_w[g]),
          e_iss[g] ? 32'(rw[e_w[g]]) : 32'd1);
      chk($sformatf("i%0d.addr", g), 32'(addr_w[g]),
          e_iss[g] ? 32'(addr[e_w[g]*18 +: 18]) : 32'd0);
      chk($sformatf("i%0d.wdata", g), 32'(wdata_w[g]),
          e_iss[g] ? 32'(wdata[e_w[g]*16 +: 16]) : 32'd0);
      erv = (!reset && infl[g] && infl_rd[g] && rdy) ?
            2'(1 << infl_own[g]) : 2'b00;
      chk($sformatf("i%0d.rvalid", g), 32'(rvalid_w[g]), 32'(erv));
      if (erv != 2'b00)
        chk($sformatf("i%0d.rdata", g), 32'(rdata_o_w[g]), 32'(infl_dat[g]));
    end
  endtask

  task automatic update();
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        last[g] = 1;
        infl[g] = 1'b0;
        bsy[g]  = 1'b0;
      end else begin
        if (infl[g] && !hold && !bsy[g]) infl[g] = 1'b0;
        bsy[g] = e_iss[g];
        if (e_iss[g]) begin
          infl[g]     = 1'b1;
          infl_rd[g]  = rw[e_w[g]];
          infl_own[g] = e_w[g];
          infl_dat[g] = mdata(addr[e_w[g]*18 +: 18]);
          last[g]     = e_w[g];
        end
      end
    end
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      @(posedge clk);
      update();
      #1;
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      last[g] = 1;
      infl[g] = 1'b0;
      bsy[g]  = 1'b0;
    end
    // reset state, with a request pending that must not issue
    req = 2'b11;
    rw  = 2'b11;
    cyc(3);
    req   = 2'b00;
    reset = 1'b0;
    cyc(1);
    // single read from requester 0
    req  = 2'b01;
    rw   = 2'b01;
    addr = {18'h0, 18'h00010};
    cyc(1);
    req = 2'b00;
    cyc(4);
    // single write from requester 1 to the top address
    req   = 2'b10;
    rw    = 2'b00;
    addr  = {18'h3FFFF, 18'h0};
    wdata = {16'hA5A5, 16'h0};
    cyc(1);
    req = 2'b00;
    cyc(5);
    // both reading continuously, then requester 0 drops out
    req  = 2'b11;
    rw   = 2'b11;
    addr = {18'h00123, 18'h00456};
    cyc(9);
    req = 2'b10;
    cyc(4);
    req = 2'b00;
    cyc(3);
    // controller stalled with both requesting
    hold = 1'b1;
    req  = 2'b11;
    cyc(5);
    hold = 1'b0;
    cyc(1);
    req = 2'b00;
    cyc(3);
    // reset in the middle of a read
    req = 2'b01;
    rw  = 2'b11;
    cyc(1);
    req   = 2'b00;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    req   = 2'b11;
    cyc(2);
    req = 2'b00;
    cyc(2);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      req   = 2'($urandom_range(0, 3));
      rw    = 2'($urandom_range(0, 3));
      addr  = {4'($urandom), $urandom};
      wdata = $urandom;
      hold  = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    reset = 1'b0;
    hold  = 1'b0;
    req   = 2'b00;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
